// File: rtl/key_debounce_array_pkg.sv
// Shared types and constants for the key debounce array.
package key_debounce_array_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    KD_IDLE    = 2'd0,
    KD_DEB_P   = 2'd1,
    KD_PRESSED = 2'd2,
    KD_DEB_R   = 2'd3
  } kd_state_e;

  // Timing constants for a 50 MHz clock: 20 ms debounce, 1 s long press, 200 ms repeat.
  localparam int KD_DEB_CYCLES_50M    = 1_000_000;
  localparam int KD_LONG_CYCLES_50M   = 50_000_000;
  localparam int KD_REPEAT_CYCLES_50M = 10_000_000;

  // Timer width able to hold the largest of the three cycle counts.
  function automatic int kd_cnt_w(input int deb, input int lng, input int rep);
    int m;
    m = deb;
    if (lng > m) m = lng;
    if (rep > m) m = rep;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_debounce_array_if.sv
// Key pins, counter clear and all per-key event/level outputs.
interface key_debounce_array_if #(
  parameter int N_KEYS = 4,
  parameter int CNT_W  = 4
);
  logic [N_KEYS-1:0]       i_key;
  logic                    i_clr_cnt;
  logic [N_KEYS-1:0]       o_level;
  logic [N_KEYS-1:0]       o_press;
  logic [N_KEYS-1:0]       o_release;
  logic [N_KEYS-1:0]       o_long;
  logic [N_KEYS-1:0]       o_repeat;
  logic                    o_any;
  logic [N_KEYS*CNT_W-1:0] o_press_cnt;

  modport slave (
    input  i_key, i_clr_cnt,
    output o_level, o_press, o_release, o_long, o_repeat, o_any, o_press_cnt
  );

  modport master (
    output i_key, i_clr_cnt,
    input  o_level, o_press, o_release, o_long, o_repeat, o_any, o_press_cnt
  );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, long-press/auto-repeat
// timers and a wrapping press counter. All outputs are registered.
module key_debounce_ch
  import key_debounce_array_pkg::*;
#(
  parameter int ACTIVE_LOW    = 1,
  parameter int DEB_CYCLES    = 20000,
  parameter int LONG_CYCLES   = 1000000,
  parameter int REPEAT_CYCLES = 200000,
  parameter int CNT_W         = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_key,
  input  logic             i_clr_cnt,
  output logic             o_level,
  output logic             o_press,
  output logic             o_release,
  output logic             o_long,
  output logic             o_repeat,
  output logic [CNT_W-1:0] o_press_cnt
);

  localparam int            TW       = kd_cnt_w(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
  localparam logic          REL_LVL  = (ACTIVE_LOW != 0);
  localparam logic          REP_EN   = (REPEAT_CYCLES != 0);
  localparam logic [TW-1:0] DEB_LAST = TW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST = REP_EN ? TW'(REPEAT_CYCLES - 1) : '0;
  localparam logic [TW-1:0] HOLD_MAX = '1;

  logic [1:0]       sync_q, sync_d;
  kd_state_e        state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    hold_q, hold_d;
  logic [TW-1:0]    rep_q, rep_d;
  logic             long_done_q, long_done_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             p;

  // Normalised pressed level from the synchroniser output.
  assign p = sync_q[1] ^ REL_LVL;

  // State register; synchroniser resets to the released pin level so a key
  // held through reset is seen as a fresh press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q      <= {2{REL_LVL}};
      state_q     <= KD_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      rep_q       <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
      pcnt_q      <= '0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
      pcnt_q      <= pcnt_d;
    end
  end

  // Next-state, timers and event pulses.
  always_comb begin
    sync_d      = {sync_q[0], i_key};
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    rep_d       = rep_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    // Counter acts on the cycle o_press is visible, so a coincident clear yields 1.
    pcnt_d      = i_clr_cnt ? CNT_W'(press_q) : pcnt_q + CNT_W'(press_q);

    case (state_q)
      KD_IDLE: begin
        if (p) begin
          state_d = KD_DEB_P;
          cnt_d   = '0;
        end
      end
      KD_DEB_P: begin
        if (!p) begin
          state_d = KD_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = KD_PRESSED;
          press_d = 1'b1;
          level_d = 1'b1;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      KD_PRESSED: begin
        if (!p) begin
          // Timers freeze while a release is being qualified.
          state_d = KD_DEB_R;
          cnt_d   = '0;
        end else begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
          if (!long_done_q && hold_q == LONG_LAST) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
            rep_d       = '0;
          end else if (long_done_q && REP_EN) begin
            if (rep_q == REP_LAST) begin
              repeat_d = 1'b1;
              rep_d    = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
        end
      end
      KD_DEB_R: begin
        if (p) begin
          state_d = KD_PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = KD_IDLE;
          release_d   = 1'b1;
          level_d     = 1'b0;
          long_done_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = KD_IDLE;
    endcase
  end

  assign o_level     = level_q;
  assign o_press     = press_q;
  assign o_release   = release_q;
  assign o_long      = long_q;
  assign o_repeat    = repeat_q;
  assign o_press_cnt = pcnt_q;

endmodule

// File: rtl/key_debounce_array.sv
// N-channel push-button front end: one key_debounce_ch per key, plus packing
// of the per-channel counters and the any-key-pressed OR.
module key_debounce_array
  import key_debounce_array_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DEB_CYCLES    = 20000,
  parameter int LONG_CYCLES   = 1000000,
  parameter int REPEAT_CYCLES = 200000,
  parameter int CNT_W         = 4
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  key_debounce_array_if.slave  bus
);

  logic [N_KEYS-1:0]            level_w, press_w, release_w, long_w, repeat_w;
  logic [N_KEYS-1:0][CNT_W-1:0] cnt_w;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .ACTIVE_LOW    (ACTIVE_LOW),
      .DEB_CYCLES    (DEB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .CNT_W         (CNT_W)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_key       (bus.i_key[g]),
      .i_clr_cnt   (bus.i_clr_cnt),
      .o_level     (level_w[g]),
      .o_press     (press_w[g]),
      .o_release   (release_w[g]),
      .o_long      (long_w[g]),
      .o_repeat    (repeat_w[g]),
      .o_press_cnt (cnt_w[g])
    );
  end

  // Packed array layout puts channel k at [k*CNT_W +: CNT_W].
  assign bus.o_level     = level_w;
  assign bus.o_press     = press_w;
  assign bus.o_release   = release_w;
  assign bus.o_long      = long_w;
  assign bus.o_repeat    = repeat_w;
  assign bus.o_any       = |level_w;
  assign bus.o_press_cnt = cnt_w;

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: vector table, directed corner sequences and
// random pin activity, all checked every cycle against a run-length model.
module tb_key_debounce_array;
  localparam int N = 4, DEB = 4, LONG = 16, REP = 8, CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_debounce_array_if #(.N_KEYS(N), .CNT_W(CW)) bus ();

  key_debounce_array #(
    .N_KEYS(N), .ACTIVE_LOW(1), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG),
    .REPEAT_CYCLES(REP), .CNT_W(CW)
  ) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int checks = 0, passes = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", name, cyc, act, exp);
  endtask

  // Model: a level change is accepted once the pin has disagreed with the
  // accepted level for DEB+1 consecutive cycles (2 cycles after being driven).
  // Long/repeat count cycles spent steadily pressed.
  logic [3:0]    pin_m1, pin_m2;
  int            m_run[N], m_hold[N], m_rep[N];
  bit            m_lvl[N], m_done[N];
  logic [3:0]    e_press, e_rel, e_long, e_rep;
  logic [CW-1:0] e_cnt[N];

  task automatic model_reset();
    pin_m1 = 4'hF; pin_m2 = 4'hF;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    for (int k = 0; k < N; k++) begin
      m_run[k] = 0; m_hold[k] = 0; m_rep[k] = 0;
      m_lvl[k] = 0; m_done[k] = 0; e_cnt[k] = '0;
    end
  endtask

  task automatic model_step(input logic [3:0] key, input logic clr);
    logic [3:0] p, np, nr, nl, nrp;
    bit steady;
    p = ~pin_m2;
    pin_m2 = pin_m1; pin_m1 = key;
    np = '0; nr = '0; nl = '0; nrp = '0;
    for (int k = 0; k < N; k++) begin
      e_cnt[k] = clr ? CW'(e_press[k]) : e_cnt[k] + CW'(e_press[k]);
      steady = m_lvl[k] && (m_run[k] == 0);
      if (steady && p[k]) begin
        m_hold[k]++;
        if (!m_done[k] && m_hold[k] == LONG) begin
          nl[k] = 1'b1; m_done[k] = 1; m_rep[k] = 0;
        end else if (m_done[k]) begin
          m_rep[k]++;
          if (m_rep[k] == REP) begin nrp[k] = 1'b1; m_rep[k] = 0; end
        end
      end
      if (p[k] != m_lvl[k]) m_run[k]++; else m_run[k] = 0;
      if (m_run[k] == DEB + 1) begin
        m_lvl[k] = p[k]; m_run[k] = 0;
        if (p[k]) begin np[k] = 1'b1; m_hold[k] = 0; end
        else begin nr[k] = 1'b1; m_done[k] = 0; end
      end
    end
    e_press = np; e_rel = nr; e_long = nl; e_rep = nrp;
  endtask

  function automatic logic [63:0] exp_vec();
    logic [3:0] l;
    for (int k = 0; k < N; k++) l[k] = m_lvl[k];
    return {31'b0, l, e_press, e_rel, e_long, e_rep, |l, e_cnt[3], e_cnt[2], e_cnt[1], e_cnt[0]};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {31'b0, bus.o_level, bus.o_press, bus.o_release, bus.o_long, bus.o_repeat,
            bus.o_any, bus.o_press_cnt};
  endfunction

  // Drive one cycle of inputs, advance one clock and compare against the model.
  task automatic step(input logic [3:0] key, input logic clr);
    bus.i_key = key; bus.i_clr_cnt = clr;
    model_step(key, clr);
    @(posedge clk); #1; cyc++;
    chk("model", dut_vec(), exp_vec());
  endtask

  typedef struct {
    logic [3:0] key; logic clr;
    logic [3:0] press; logic [3:0] rel; logic [3:0] lvl; logic [2:0] cnt0;
  } vec_t;
  vec_t tbl[20];

  int pulses1, rel1, long1, t_press, t_long, t_rel, t_rise, nrep;
  int reps[$];
  logic [3:0] rk;

  initial begin
    bus.i_key = 4'hF; bus.i_clr_cnt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", dut_vec(), 64'd0);
    rst_n = 1'b1;

    // 1. clean press/release of key0 as a vector table
    for (int i = 0; i < 20; i++)
      tbl[i] = '{key: (i < 10) ? 4'b1110 : 4'b1111, clr: 1'b0, press: 4'b0, rel: 4'b0,
                 lvl: (i >= 6 && i < 16) ? 4'b0001 : 4'b0, cnt0: (i >= 7) ? 3'd1 : 3'd0};
    tbl[6].press = 4'b0001;
    tbl[16].rel  = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].key, tbl[i].clr);
      chk("tbl_press", 64'(bus.o_press), 64'(tbl[i].press));
      chk("tbl_release", 64'(bus.o_release), 64'(tbl[i].rel));
      chk("tbl_level", 64'(bus.o_level), 64'(tbl[i].lvl));
      chk("tbl_cnt0", 64'(bus.o_press_cnt[2:0]), 64'(tbl[i].cnt0));
    end

    // 2. bounce on key1, then a short release glitch while pressed
    pulses1 = 0;
    for (int i = 0; i < 28; i++) begin
      step((i < 20 && ((i / 2) % 2) == 0) ? 4'b1101 : 4'b1111, 1'b0);
      pulses1 += int'(bus.o_press[1]) + int'(bus.o_release[1]) + int'(bus.o_long[1]) + int'(bus.o_repeat[1]);
    end
    chk("bounce_no_pulse", 64'(pulses1), 64'd0);
    chk("bounce_level", 64'(bus.o_level[1]), 64'd0);
    rel1 = 0; long1 = 0;
    for (int i = 0; i < 23; i++) begin
      step((i >= 10 && i < 13) ? 4'b1111 : 4'b1101, 1'b0);
      rel1 += int'(bus.o_release[1]); long1 += int'(bus.o_long[1]);
    end
    chk("glitch_no_release", 64'(rel1), 64'd0);
    chk("glitch_level", 64'(bus.o_level[1]), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 1'b0);
      rel1 += int'(bus.o_release[1]); long1 += int'(bus.o_long[1]);
    end
    chk("glitch_final_release", 64'(rel1), 64'd1);
    chk("glitch_no_long", 64'(long1), 64'd0);

    // 3. long press and auto-repeat on key2
    t_press = -1; t_long = -1; t_rel = -1; reps.delete();
    for (int i = 0; i < 67; i++) begin
      step(4'b1011, 1'b0);
      if (bus.o_press[2]) t_press = cyc;
      if (bus.o_long[2]) t_long = cyc;
      if (bus.o_repeat[2]) reps.push_back(cyc);
    end
    t_rise = cyc;
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 1'b0);
      if (bus.o_release[2]) t_rel = cyc;
      if (bus.o_repeat[2]) reps.push_back(cyc);
    end
    chk("long_offset", 64'(t_long - t_press), 64'd16);
    nrep = reps.size();
    chk("repeat_count", 64'(nrep), 64'd5);
    for (int j = 0; j < nrep && j < 5; j++)
      chk("repeat_offset", 64'(reps[j] - t_press), 64'(24 + 8 * j));
    chk("release_latency", 64'(t_rel - t_rise), 64'd7);
    t_press = -1; t_long = -1;
    for (int i = 0; i < 25; i++) begin
      step(4'b1011, 1'b0);
      if (bus.o_press[2]) t_press = cyc;
      if (bus.o_long[2]) t_long = cyc;
    end
    chk("long_again", 64'(t_long - t_press), 64'd16);
    for (int i = 0; i < 10; i++) step(4'b1111, 1'b0);

    // 4. counter wrap and clear on key3
    step(4'b1111, 1'b1);
    chk("cnt3_cleared", 64'(bus.o_press_cnt[9 +: 3]), 64'd0);
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 10; i++) step(4'b0111, 1'b0);
      for (int i = 0; i < 10; i++) step(4'b1111, 1'b0);
      if (n == 6) chk("cnt3_seven", 64'(bus.o_press_cnt[9 +: 3]), 64'd7);
      if (n == 7) chk("cnt3_wrap", 64'(bus.o_press_cnt[9 +: 3]), 64'd0);
    end
    for (int i = 0; i < 10; i++) step(4'b0111, (i == 7) ? 1'b1 : 1'b0);
    chk("cnt3_clr_with_press", 64'(bus.o_press_cnt[9 +: 3]), 64'd1);
    for (int i = 0; i < 10; i++) step(4'b1111, 1'b0);

    // 5. all keys pressed on the same edge
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, 1'b0);
      if (i == 6) begin
        chk("simul_press", 64'(bus.o_press), 64'hF);
        chk("simul_any", 64'(bus.o_any), 64'd1);
      end
    end
    for (int i = 0; i < 10; i++) step(4'b1111, 1'b0);

    // 6. reset while key0 is held, key kept down through reset release
    for (int i = 0; i < 10; i++) step(4'b1110, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_hold", dut_vec(), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; cyc += 2;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step(4'b1110, 1'b0);
      if (i == 6) chk("post_reset_press", 64'(bus.o_press), 64'h1);
    end
    chk("post_reset_cnt0", 64'(bus.o_press_cnt[2:0]), 64'd1);

    // Random pin activity; key3 changes slowly enough to reach long/repeat.
    rk = bus.i_key;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, (c == 3) ? 39 : 3 + 4 * c) == 0) rk[c] = ~rk[c];
      step(rk, ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
